// File: rtl/vx_mem_traffic_gen_if.sv
// Memory request/response bus between the traffic generator (master) and the memory system (slave).
interface vx_mem_traffic_gen_if #(
  parameter int DATA_WIDTH = 512,
  parameter int ADDR_WIDTH = 26,
  parameter int TAG_WIDTH  = 8
);
  logic                    mem_req_valid;
  logic                    mem_req_rw;
  logic [DATA_WIDTH/8-1:0] mem_req_byteen;
  logic [ADDR_WIDTH-1:0]   mem_req_addr;
  logic [DATA_WIDTH-1:0]   mem_req_data;
  logic [TAG_WIDTH-1:0]    mem_req_tag;
  logic                    mem_req_ready;
  logic                    mem_rsp_valid;
  logic [DATA_WIDTH-1:0]   mem_rsp_data;
  logic [TAG_WIDTH-1:0]    mem_rsp_tag;
  logic                    mem_rsp_ready;

  modport master (
    output mem_req_valid, mem_req_rw, mem_req_byteen, mem_req_addr, mem_req_data, mem_req_tag,
    input  mem_req_ready,
    input  mem_rsp_valid, mem_rsp_data, mem_rsp_tag,
    output mem_rsp_ready
  );

  modport slave (
    input  mem_req_valid, mem_req_rw, mem_req_byteen, mem_req_addr, mem_req_data, mem_req_tag,
    output mem_req_ready,
    output mem_rsp_valid, mem_rsp_data, mem_rsp_tag,
    input  mem_rsp_ready
  );
endinterface

// File: rtl/vx_mem_traffic_gen.sv
// DCR-programmed strided memory traffic generator with bounded reads in flight and
// read-data checking against an address-derived pattern.
module vx_mem_traffic_gen #(
  parameter int          DATA_WIDTH      = 512,
  parameter int          ADDR_WIDTH      = 26,
  parameter int          TAG_WIDTH       = 8,
  parameter int          MAX_OUTSTANDING = 4,
  parameter int unsigned START_DELAY     = 65000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  dcr_wr_valid,
  input  logic [11:0]           dcr_wr_addr,
  input  logic [31:0]           dcr_wr_data,
  vx_mem_traffic_gen_if.master  mem,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           err_cnt
);

  localparam int IDXW  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int OCW   = $clog2(MAX_OUTSTANDING + 1);
  localparam int WORDS = DATA_WIDTH / 32;

  typedef enum logic [2:0] {ST_IDLE, ST_DELAY, ST_ISSUE, ST_DRAIN, ST_DONE} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [31:0]           count_q, count_d;
  logic [ADDR_WIDTH-1:0] stride_q, stride_d;
  logic                  mode_q, mode_d;
  logic [31:0]           delay_q, delay_d;
  logic [31:0]           idx_q, idx_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [OCW-1:0]        outst_q, outst_d;
  logic [15:0]           err_q, err_d;
  logic                  done_q, done_d;
  logic                  req_valid_q, req_valid_d;
  logic                  req_rw_q, req_rw_d;
  logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
  logic [DATA_WIDTH-1:0] req_data_q, req_data_d;
  logic [TAG_WIDTH-1:0]  req_tag_q, req_tag_d;
  logic [ADDR_WIDTH-1:0] tbl_q [MAX_OUTSTANDING];
  logic [ADDR_WIDTH-1:0] tbl_d [MAX_OUTSTANDING];

  logic                  cfg_en, rsp_ready, req_fire, rd_req, rd_rsp;
  logic [31:0]           idx_n;
  logic [ADDR_WIDTH-1:0] addr_n;
  logic                  unused_tag_bits;

  function automatic logic [DATA_WIDTH-1:0] pattern(input logic [ADDR_WIDTH-1:0] a);
    return {WORDS{32'(a)}};
  endfunction

  assign cfg_en          = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign rsp_ready       = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
  assign req_fire        = req_valid_q & mem.mem_req_ready;
  assign rd_req          = req_fire & ~mode_q;
  assign rd_rsp          = mem.mem_rsp_valid & rsp_ready & ~mode_q;
  assign unused_tag_bits = ^mem.mem_rsp_tag;

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    count_d     = count_q;
    stride_d    = stride_q;
    mode_d      = mode_q;
    delay_d     = delay_q;
    idx_d       = idx_q;
    addr_d      = addr_q;
    outst_d     = outst_q;
    err_d       = err_q;
    done_d      = done_q;
    req_valid_d = req_valid_q;
    req_rw_d    = req_rw_q;
    req_addr_d  = req_addr_q;
    req_data_d  = req_data_q;
    req_tag_d   = req_tag_q;
    tbl_d       = tbl_q;
    idx_n       = idx_q + {31'd0, req_fire};
    addr_n      = req_fire ? addr_q + stride_q : addr_q;

    case ({rd_req, rd_rsp})
      2'b10:   outst_d = outst_q + 1'b1;
      2'b01:   outst_d = outst_q - 1'b1;
      default: ;
    endcase

    if (rd_req) tbl_d[req_tag_q[IDXW-1:0]] = req_addr_q;

    if (rd_rsp && (mem.mem_rsp_data != pattern(tbl_q[mem.mem_rsp_tag[IDXW-1:0]])) &&
        (err_q != 16'hFFFF))
      err_d = err_q + 16'd1;

    case (state_q)
      ST_DELAY: begin
        if (count_q == 32'd0) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else if (delay_q == 32'd0) begin
          state_d = ST_ISSUE;
        end else begin
          delay_d = delay_q - 32'd1;
        end
      end
      ST_ISSUE: begin
        idx_d  = idx_n;
        addr_d = addr_n;
        if (req_fire && (idx_n == count_q)) begin
          req_valid_d = 1'b0;
          state_d     = ST_DRAIN;
        end else if (!req_valid_q || req_fire) begin
          // Read throttling uses the post-update count, so a response landing this
          // cycle immediately frees a slot for the next presentation.
          if (mode_q || (outst_d < OCW'(MAX_OUTSTANDING))) begin
            req_valid_d = 1'b1;
            req_rw_d    = mode_q;
            req_addr_d  = addr_n;
            req_tag_d   = idx_n[TAG_WIDTH-1:0];
            req_data_d  = pattern(addr_n);
          end else begin
            req_valid_d = 1'b0;
          end
        end
      end
      ST_DRAIN: begin
        if (outst_q == '0) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end
      end
      default: ;
    endcase

    if (dcr_wr_valid && cfg_en) begin
      case (dcr_wr_addr)
        12'h000: base_d   = dcr_wr_data[ADDR_WIDTH-1:0];
        12'h001: count_d  = dcr_wr_data;
        12'h002: stride_d = dcr_wr_data[ADDR_WIDTH-1:0];
        12'h003: begin
          if (dcr_wr_data[0]) begin
            mode_d  = dcr_wr_data[1];
            done_d  = 1'b0;
            err_d   = '0;
            idx_d   = '0;
            addr_d  = base_q;
            outst_d = '0;
            delay_d = (START_DELAY == 0) ? 32'd0 : 32'(START_DELAY - 1);
            state_d = ((START_DELAY == 0) && (count_q != 32'd0)) ? ST_ISSUE : ST_DELAY;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      base_q      <= '0;
      count_q     <= '0;
      stride_q    <= '0;
      mode_q      <= 1'b0;
      delay_q     <= '0;
      idx_q       <= '0;
      addr_q      <= '0;
      outst_q     <= '0;
      err_q       <= '0;
      done_q      <= 1'b0;
      req_valid_q <= 1'b0;
      req_rw_q    <= 1'b0;
      req_addr_q  <= '0;
      req_data_q  <= '0;
      req_tag_q   <= '0;
      tbl_q       <= '{default: '0};
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      count_q     <= count_d;
      stride_q    <= stride_d;
      mode_q      <= mode_d;
      delay_q     <= delay_d;
      idx_q       <= idx_d;
      addr_q      <= addr_d;
      outst_q     <= outst_d;
      err_q       <= err_d;
      done_q      <= done_d;
      req_valid_q <= req_valid_d;
      req_rw_q    <= req_rw_d;
      req_addr_q  <= req_addr_d;
      req_data_q  <= req_data_d;
      req_tag_q   <= req_tag_d;
      tbl_q       <= tbl_d;
    end
  end

  assign mem.mem_req_valid  = req_valid_q;
  assign mem.mem_req_rw     = req_rw_q;
  assign mem.mem_req_byteen = '1;
  assign mem.mem_req_addr   = req_addr_q;
  assign mem.mem_req_data   = req_data_q;
  assign mem.mem_req_tag    = req_tag_q;
  assign mem.mem_rsp_ready  = rsp_ready;

  assign busy    = (state_q == ST_DELAY) || (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
  assign done    = done_q;
  assign err_cnt = err_q;

endmodule

// File: tb/tb_vx_mem_traffic_gen.sv
// Directed bench for vx_mem_traffic_gen with a 3-cycle-latency echo memory model.
module tb_vx_mem_traffic_gen;
  localparam int DW = 512;
  localparam int AW = 26;
  localparam int TW = 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          dcr_wr_valid = 1'b0;
  logic [11:0]   dcr_wr_addr = '0;
  logic [31:0]   dcr_wr_data = '0;
  logic          busy, done;
  logic [15:0]   err_cnt;

  int n_vec = 0;
  int n_err = 0;

  vx_mem_traffic_gen_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TAG_WIDTH(TW)) mif ();

  vx_mem_traffic_gen #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TAG_WIDTH(TW), .MAX_OUTSTANDING(4), .START_DELAY(4)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .dcr_wr_valid(dcr_wr_valid), .dcr_wr_addr(dcr_wr_addr), .dcr_wr_data(dcr_wr_data),
    .mem(mif), .busy(busy), .done(done), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  // memory model controls (written by tests only)
  bit ready_rand = 0;
  bit hold = 0;
  int rel_req = 0;
  int corrupt_tag = -1;

  // memory model state (written by the model only)
  logic [AW-1:0] log_addr[$];
  logic [TW-1:0] log_tag[$];
  logic          log_rw[$];
  logic [DW-1:0] log_data[$];
  logic [AW-1:0] pend_addr[$];
  logic [TW-1:0] pend_tag[$];
  int            pend_due[$];
  int cyc = 0, outst = 0, max_outst = 0, stab_viol = 0, rel_done = 0;

  initial begin : mem_model
    bit prev_stall;
    logic [AW-1:0] p_addr;
    logic [TW-1:0] p_tag;
    logic [DW-1:0] p_data;
    logic          p_rw;
    prev_stall = 0;
    mif.mem_req_ready = 1'b0;
    mif.mem_rsp_valid = 1'b0;
    mif.mem_rsp_data  = '0;
    mif.mem_rsp_tag   = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset_n) begin
        pend_addr.delete(); pend_tag.delete(); pend_due.delete();
        outst = 0; prev_stall = 0;
        mif.mem_req_ready = 1'b0;
        mif.mem_rsp_valid = 1'b0;
        continue;
      end
      if (prev_stall && (!mif.mem_req_valid || mif.mem_req_addr !== p_addr ||
          mif.mem_req_tag !== p_tag || mif.mem_req_data !== p_data || mif.mem_req_rw !== p_rw))
        stab_viol++;
      mif.mem_req_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      if (mif.mem_req_valid && mif.mem_req_ready) begin
        log_addr.push_back(mif.mem_req_addr);
        log_tag.push_back(mif.mem_req_tag);
        log_rw.push_back(mif.mem_req_rw);
        log_data.push_back(mif.mem_req_data);
        if (!mif.mem_req_rw) begin
          pend_addr.push_back(mif.mem_req_addr);
          pend_tag.push_back(mif.mem_req_tag);
          pend_due.push_back(cyc + 3);
          outst++;
        end
      end
      prev_stall = mif.mem_req_valid && !mif.mem_req_ready;
      p_addr = mif.mem_req_addr; p_tag = mif.mem_req_tag;
      p_data = mif.mem_req_data; p_rw = mif.mem_req_rw;
      mif.mem_rsp_valid = 1'b0;
      if (pend_addr.size() > 0 && pend_due[0] <= cyc && mif.mem_rsp_ready &&
          (!hold || rel_done < rel_req)) begin
        if (hold) rel_done++;
        mif.mem_rsp_valid = 1'b1;
        mif.mem_rsp_tag   = pend_tag[0];
        mif.mem_rsp_data  = {(DW/32){32'(pend_addr[0])}};
        if (int'(pend_tag[0]) == corrupt_tag) mif.mem_rsp_data[0] = ~mif.mem_rsp_data[0];
        void'(pend_addr.pop_front()); void'(pend_tag.pop_front()); void'(pend_due.pop_front());
        outst--;
      end
      if (outst > max_outst) max_outst = outst;
    end
  end

  task automatic dcr_write(input logic [11:0] a, input logic [31:0] d);
    @(negedge clk);
    dcr_wr_valid = 1'b1; dcr_wr_addr = a; dcr_wr_data = d;
    @(negedge clk);
    dcr_wr_valid = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (done) begin ok = 1; break; end
    end
  endtask

  task automatic test_reset;
    logic [DW/8-1:0] ones;
    ones = '1;
    #2 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++; if (mif.mem_req_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %b want 0", mif.mem_req_valid); end
    n_vec++; if (mif.mem_req_byteen !== ones) begin n_err++; $display("FAIL rst_byteen got %h want all ones", mif.mem_req_byteen); end
    n_vec++; if (mif.mem_req_addr !== '0 || mif.mem_req_tag !== '0 || mif.mem_req_data !== '0 || mif.mem_req_rw !== 1'b0) begin
      n_err++; $display("FAIL rst_req got addr=%h tag=%h rw=%b want 0", mif.mem_req_addr, mif.mem_req_tag, mif.mem_req_rw); end
    n_vec++; if ({busy, done, mif.mem_rsp_ready} !== 3'b000 || err_cnt !== 16'd0) begin
      n_err++; $display("FAIL rst_status got busy=%b done=%b rsp_ready=%b err=%0d want 0", busy, done, mif.mem_rsp_ready, err_cnt); end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_read;
    int b; bit ok;
    b = log_addr.size();
    dcr_write(12'h0, 32'h100); dcr_write(12'h1, 32'd8); dcr_write(12'h2, 32'd1); dcr_write(12'h3, 32'h1);
    wait_done(ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL read_done got timeout want done=1"); end
    n_vec++; if (log_addr.size() - b != 8) begin n_err++; $display("FAIL read_count got %0d want 8", log_addr.size() - b); end
    for (int i = 0; i < 8 && b + i < log_addr.size(); i++) begin
      n_vec++;
      if (log_addr[b+i] !== AW'(32'h100 + i) || log_tag[b+i] !== TW'(i) || log_rw[b+i] !== 1'b0) begin
        n_err++; $display("FAIL read_req%0d got addr=%h tag=%0d rw=%b want addr=%h tag=%0d rw=0",
                          i, log_addr[b+i], log_tag[b+i], log_rw[b+i], 32'h100 + i, i); end
    end
    n_vec++; if (err_cnt !== 16'd0) begin n_err++; $display("FAIL read_err got %0d want 0", err_cnt); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL read_busy got %b want 0", busy); end
    n_vec++; if (max_outst > 4) begin n_err++; $display("FAIL read_outstanding got %0d want <=4", max_outst); end
  endtask

  task automatic test_write;
    int b; bit ok;
    logic [AW-1:0] exp_a [4];
    logic [DW-1:0] exp_d;
    exp_a[0] = 26'h3FFFFFE; exp_a[1] = 26'h3FFFFFF; exp_a[2] = 26'h0; exp_a[3] = 26'h1;
    b = log_addr.size();
    dcr_write(12'h0, 32'h3FFFFFE); dcr_write(12'h1, 32'd4); dcr_write(12'h2, 32'd1); dcr_write(12'h3, 32'h3);
    wait_done(ok);
    n_vec++; if (!ok || log_addr.size() - b != 4) begin n_err++; $display("FAIL write_count got done=%b n=%0d want done=1 n=4", ok, log_addr.size() - b); end
    for (int i = 0; i < 4 && b + i < log_addr.size(); i++) begin
      exp_d = {(DW/32){32'(exp_a[i])}};
      n_vec++;
      if (log_addr[b+i] !== exp_a[i] || log_rw[b+i] !== 1'b1 || log_tag[b+i] !== TW'(i) || log_data[b+i] !== exp_d) begin
        n_err++; $display("FAIL write_req%0d got addr=%h rw=%b tag=%0d word0=%h want addr=%h rw=1 tag=%0d word0=%h",
                          i, log_addr[b+i], log_rw[b+i], log_tag[b+i], log_data[b+i][31:0], exp_a[i], i, exp_d[31:0]); end
    end
  endtask

  task automatic test_backpressure;
    int b, sv0; bit ok;
    b = log_addr.size(); sv0 = stab_viol;
    ready_rand = 1;
    dcr_write(12'h0, 32'h200); dcr_write(12'h1, 32'd8); dcr_write(12'h2, 32'd2); dcr_write(12'h3, 32'h1);
    wait_done(ok);
    ready_rand = 0;
    n_vec++; if (!ok || log_addr.size() - b != 8) begin n_err++; $display("FAIL bp_count got done=%b n=%0d want done=1 n=8", ok, log_addr.size() - b); end
    n_vec++; if (stab_viol != sv0) begin n_err++; $display("FAIL bp_stable got %0d violations want 0", stab_viol - sv0); end
    for (int i = 0; i < 8 && b + i < log_addr.size(); i++) begin
      n_vec++;
      if (log_addr[b+i] !== AW'(32'h200 + 2 * i) || log_tag[b+i] !== TW'(i)) begin
        n_err++; $display("FAIL bp_req%0d got addr=%h tag=%0d want addr=%h tag=%0d", i, log_addr[b+i], log_tag[b+i], 32'h200 + 2 * i, i); end
    end
    n_vec++; if (err_cnt !== 16'd0) begin n_err++; $display("FAIL bp_err got %0d want 0", err_cnt); end
  endtask

  task automatic test_withhold;
    int b; bit ok;
    b = log_addr.size();
    hold = 1;
    dcr_write(12'h0, 32'h40); dcr_write(12'h1, 32'd6); dcr_write(12'h2, 32'd1); dcr_write(12'h3, 32'h1);
    repeat (30) @(negedge clk);
    n_vec++; if (log_addr.size() - b != 4) begin n_err++; $display("FAIL hold_accepts got %0d want 4", log_addr.size() - b); end
    n_vec++; if (mif.mem_req_valid !== 1'b0) begin n_err++; $display("FAIL hold_valid got %b want 0", mif.mem_req_valid); end
    rel_req++;
    repeat (15) @(negedge clk);
    n_vec++; if (log_addr.size() - b != 5) begin n_err++; $display("FAIL release_accepts got %0d want 5", log_addr.size() - b); end
    n_vec++; if (mif.mem_req_valid !== 1'b0) begin n_err++; $display("FAIL release_valid got %b want 0", mif.mem_req_valid); end
    hold = 0;
    wait_done(ok);
    n_vec++; if (!ok || log_addr.size() - b != 6 || err_cnt !== 16'd0) begin
      n_err++; $display("FAIL hold_finish got done=%b n=%0d err=%0d want 1/6/0", ok, log_addr.size() - b, err_cnt); end
  endtask

  task automatic test_corrupt;
    int b; bit ok;
    b = log_addr.size();
    corrupt_tag = 2;
    dcr_write(12'h0, 32'h500); dcr_write(12'h1, 32'd8); dcr_write(12'h2, 32'd1); dcr_write(12'h3, 32'h1);
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL corrupt_busy got %b want 1", busy); end
    dcr_write(12'h0, 32'h999);
    wait_done(ok);
    corrupt_tag = -1;
    n_vec++; if (!ok || err_cnt !== 16'd1) begin n_err++; $display("FAIL corrupt_err got done=%b err=%0d want 1/1", ok, err_cnt); end
    n_vec++; if (log_addr.size() - b != 8) begin n_err++; $display("FAIL corrupt_count got %0d want 8", log_addr.size() - b); end
    for (int i = 0; i < 8 && b + i < log_addr.size(); i++) begin
      n_vec++;
      if (log_addr[b+i] !== AW'(32'h500 + i)) begin
        n_err++; $display("FAIL busy_base_req%0d got addr=%h want %h", i, log_addr[b+i], 32'h500 + i); end
    end
    n_vec++; if (max_outst > 4) begin n_err++; $display("FAIL corrupt_outstanding got %0d want <=4", max_outst); end
  endtask

  task automatic test_reset_mid;
    int b; bit ok, seen;
    dcr_write(12'h0, 32'h100); dcr_write(12'h1, 32'd8); dcr_write(12'h3, 32'h1);
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (mif.mem_req_valid) begin seen = 1; break; end
    end
    n_vec++; if (!seen) begin n_err++; $display("FAIL midrst_issue got no request want valid=1"); end
    reset_n = 1'b0;
    #1;
    n_vec++; if (mif.mem_req_valid !== 1'b0 || mif.mem_req_addr !== '0 || mif.mem_req_tag !== '0 || mif.mem_req_data !== '0) begin
      n_err++; $display("FAIL midrst_req got valid=%b addr=%h tag=%h want 0", mif.mem_req_valid, mif.mem_req_addr, mif.mem_req_tag); end
    n_vec++; if ({busy, done, mif.mem_rsp_ready} !== 3'b000) begin
      n_err++; $display("FAIL midrst_status got busy=%b done=%b rsp_ready=%b want 0", busy, done, mif.mem_rsp_ready); end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    b = log_addr.size();
    dcr_write(12'h1, 32'd0); dcr_write(12'h3, 32'h1);
    wait_done(ok);
    repeat (5) @(negedge clk);
    n_vec++; if (!ok || busy !== 1'b0) begin n_err++; $display("FAIL zero_done got done=%b busy=%b want 1/0", ok, busy); end
    n_vec++; if (log_addr.size() != b) begin n_err++; $display("FAIL zero_reqs got %0d want 0", log_addr.size() - b); end
  endtask

  initial begin
    test_reset;
    test_read;
    test_write;
    test_backpressure;
    test_withhold;
    test_corrupt;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
